// File: rtl/main_mem_responder.sv
// Single-ported line memory model serving writeback, data-read and instruction-read
// requests one at a time with a fixed request-to-completion latency.
//
// state | meaning
// IDLE  | waiting; requests sampled here (wrReq > dRdReq > iRdReq)
// BUSY  | latency down-counter running for the latched operation
// RESP  | completion pulse cycle; write committed / read captured on entry
module main_mem_responder #(
   parameter int MEM_LATENCY   = 5,
   parameter int LINE_IDX_BITS = 10
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [31:0]  dRdAddr,
   input  logic         dRdReq,
   output logic [127:0] dRdData,
   output logic         dRdValid,
   input  logic [31:0]  iRdAddr,
   input  logic         iRdReq,
   output logic [127:0] iRdData,
   output logic         iRdValid,
   input  logic [31:0]  wrAddr,
   input  logic         wrReq,
   input  logic [127:0] wrLine,
   output logic         wrDone,
   output logic         busy
);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
   typedef enum logic [1:0] {GNT_NONE, GNT_WR, GNT_DRD, GNT_IRD} grant_t;

   localparam int CNT_W = 4;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 2);

   state_t                   state, stateNext;
   grant_t                   grant, grantNext;
   logic [CNT_W-1:0]         cnt, cntNext;
   logic [LINE_IDX_BITS-1:0] idx, idxNext;
   logic [127:0]             lineBuf, lineBufNext;
   logic                     commit;

   logic [127:0] mem [2**LINE_IDX_BITS];

   // Byte offset and bits above the line index are don't-care (address wraps).
   logic unusedAddrBits;
   assign unusedAddrBits = ^{dRdAddr[31:LINE_IDX_BITS+4], dRdAddr[3:0],
                             iRdAddr[31:LINE_IDX_BITS+4], iRdAddr[3:0],
                             wrAddr[31:LINE_IDX_BITS+4],  wrAddr[3:0]};

   always_comb begin
      stateNext   = state;
      grantNext   = grant;
      cntNext     = cnt;
      idxNext     = idx;
      lineBufNext = lineBuf;
      case (state)
         IDLE: begin
            if (wrReq) begin
               grantNext   = GNT_WR;
               idxNext     = wrAddr[LINE_IDX_BITS+3:4];
               lineBufNext = wrLine;
               cntNext     = CNT_LOAD;
               stateNext   = BUSY;
            end else if (dRdReq) begin
               grantNext = GNT_DRD;
               idxNext   = dRdAddr[LINE_IDX_BITS+3:4];
               cntNext   = CNT_LOAD;
               stateNext = BUSY;
            end else if (iRdReq) begin
               grantNext = GNT_IRD;
               idxNext   = iRdAddr[LINE_IDX_BITS+3:4];
               cntNext   = CNT_LOAD;
               stateNext = BUSY;
            end
         end
         BUSY: begin
            if (cnt == '0) stateNext = RESP;
            else           cntNext   = cnt - 1'b1;
         end
         RESP: begin
            stateNext = IDLE;
            grantNext = GNT_NONE;
         end
         default: stateNext = IDLE;
      endcase
   end

   assign commit   = (state == BUSY) && (cnt == '0);
   assign busy     = (state != IDLE);
   assign wrDone   = (state == RESP) && (grant == GNT_WR);
   assign dRdValid = (state == RESP) && (grant == GNT_DRD);
   assign iRdValid = (state == RESP) && (grant == GNT_IRD);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state   <= IDLE;
         grant   <= GNT_NONE;
         cnt     <= '0;
         idx     <= '0;
         lineBuf <= '0;
         dRdData <= '0;
         iRdData <= '0;
      end else begin
         state   <= stateNext;
         grant   <= grantNext;
         cnt     <= cntNext;
         idx     <= idxNext;
         lineBuf <= lineBufNext;
         if (commit && grant == GNT_DRD) dRdData <= mem[idx];
         if (commit && grant == GNT_IRD) iRdData <= mem[idx];
      end
   end

   // Storage has no reset; a reset edge suppresses the pending commit.
   always_ff @(posedge clk) begin
      if (rst && commit && grant == GNT_WR) mem[idx] <= lineBuf;
   end

endmodule

// File: tb/tb_main_mem_responder.sv
// Randomized and directed bench for main_mem_responder, checked every cycle against
// an edge-counting transaction model of the responder.
module tb_main_mem_responder;
   localparam int L  = 5;
   localparam int IB = 10;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic [31:0]  dRdAddr = '0, iRdAddr = '0, wrAddr = '0;
   logic         dRdReq = 1'b0, iRdReq = 1'b0, wrReq = 1'b0;
   logic [127:0] wrLine = '0;
   logic [127:0] dRdData, iRdData;
   logic         dRdValid, iRdValid, wrDone, busy;

   always #5 clk = ~clk;

   main_mem_responder #(.MEM_LATENCY(L), .LINE_IDX_BITS(IB)) dut (
      .clk(clk), .rst(rst),
      .dRdAddr(dRdAddr), .dRdReq(dRdReq), .dRdData(dRdData), .dRdValid(dRdValid),
      .iRdAddr(iRdAddr), .iRdReq(iRdReq), .iRdData(iRdData), .iRdValid(iRdValid),
      .wrAddr(wrAddr), .wrReq(wrReq), .wrLine(wrLine), .wrDone(wrDone),
      .busy(busy)
   );

   int tests = 0, failures = 0, edgeNo = 0;
   int wrEdge = -1, dEdge = -1, iEdge = -1, multiSeen = 0;

   // Transaction model: one operation at a time, pulse on edge (sample + L - 1).
   logic [127:0] mdlMem [int];
   bit           mActive = 0;
   int           mRespEdge = 0, mKind = 0, mIdx = 0;
   logic [127:0] mLine = '0, mDData = '0, mIData = '0;
   logic         mWr = 0, mD = 0, mI = 0;

   localparam logic [127:0] LINE_A = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
   localparam logic [127:0] LINE_B = 128'hDEAD_BEEF_CAFE_F00D_1357_9BDF_2468_ACE0;
   localparam logic [127:0] LINE_C = 128'h1111_2222_3333_4444_5555_6666_7777_8888;

   function automatic int lineOf(input logic [31:0] a);
      return int'((a >> 4) % (32'd1 << IB));
   endfunction

   function automatic logic [31:0] randAddr();
      logic [31:0] a;
      a = $urandom;
      a[13:4] = 10'($urandom_range(0, 7));
      return a;
   endfunction

   function automatic logic [127:0] randLine();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edgeNo);
      end
   endtask

   task automatic step();
      @(posedge clk);
      edgeNo++;
      mWr = 0; mD = 0; mI = 0;
      if (!rst) begin
         mActive = 0;
         mDData  = '0;
         mIData  = '0;
      end else if (mActive) begin
         if (edgeNo == mRespEdge) begin
            case (mKind)
               0: begin mdlMem[mIdx] = mLine; mWr = 1; end
               1: begin mDData = mdlMem[mIdx]; mD = 1; end
               default: begin mIData = mdlMem[mIdx]; mI = 1; end
            endcase
         end else if (edgeNo > mRespEdge) begin
            mActive = 0;
         end
      end else if (wrReq || dRdReq || iRdReq) begin
         mActive   = 1;
         mRespEdge = edgeNo + L - 1;
         if (wrReq) begin
            mKind = 0; mIdx = lineOf(wrAddr); mLine = wrLine;
         end else if (dRdReq) begin
            mKind = 1; mIdx = lineOf(dRdAddr);
         end else begin
            mKind = 2; mIdx = lineOf(iRdAddr);
         end
      end
      #1;
      check("busy", 128'(busy), 128'(mActive));
      check("pulses", 128'({wrDone, dRdValid, iRdValid}), 128'({mWr, mD, mI}));
      check("dRdData", dRdData, mDData);
      check("iRdData", iRdData, mIData);
      if (int'(wrDone) + int'(dRdValid) + int'(iRdValid) > 1) multiSeen++;
      if (wrDone)   begin wrEdge = edgeNo; wrReq  = 1'b0; end
      if (dRdValid) begin dEdge  = edgeNo; dRdReq = 1'b0; end
      if (iRdValid) begin iEdge  = edgeNo; iRdReq = 1'b0; end
   endtask

   task automatic runSteps(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   task automatic clearEdges();
      wrEdge = -1; dEdge = -1; iEdge = -1;
   endtask

   int e0;

   initial begin
      runSteps(3);
      check("rstBusy", 128'(busy), 128'(0));
      check("rstDData", dRdData, 128'(0));
      rst = 1'b1;
      runSteps(2);

      for (int k = 0; k < 8; k++) begin
         wrAddr = 32'(k) << 4;
         wrLine = randLine();
         wrReq  = 1'b1;
         runSteps(L + 2);
      end

      // write then read same line, requested together
      clearEdges(); e0 = edgeNo;
      wrAddr = 32'h0000_1000; wrLine = LINE_A; dRdAddr = 32'h0000_1000;
      wrReq = 1'b1; dRdReq = 1'b1;
      runSteps(16);
      check("wrDoneEdge", 128'(wrEdge - e0), 128'(5));
      check("dAfterWr", 128'(dEdge - wrEdge), 128'(6));
      check("dReadBack", dRdData, LINE_A);

      // data and instruction reads together
      clearEdges(); e0 = edgeNo;
      dRdAddr = 32'h0000_0010; iRdAddr = 32'h0000_1000;
      dRdReq = 1'b1; iRdReq = 1'b1;
      runSteps(16);
      check("dFirst", 128'(dEdge - e0), 128'(5));
      check("iAfterD", 128'(iEdge - dEdge), 128'(6));
      check("iReadA", iRdData, LINE_A);

      // all three to one line
      clearEdges(); e0 = edgeNo;
      wrAddr = 32'h0000_1004; wrLine = LINE_B;
      dRdAddr = 32'h0000_1008; iRdAddr = 32'h0000_100C;
      wrReq = 1'b1; dRdReq = 1'b1; iRdReq = 1'b1;
      runSteps(22);
      check("tripleWr", 128'(wrEdge - e0), 128'(5));
      check("tripleD", 128'(dEdge - e0), 128'(11));
      check("tripleI", 128'(iEdge - e0), 128'(17));
      check("tripleDData", dRdData, LINE_B);
      check("tripleIData", iRdData, LINE_B);

      // wrap-around alias
      wrAddr = 32'h0000_1010; wrLine = LINE_C; wrReq = 1'b1;
      runSteps(L + 2);
      dRdAddr = 32'h0000_1010; iRdAddr = 32'h0000_1010 + (32'd1024 << 4);
      dRdReq = 1'b1; iRdReq = 1'b1;
      runSteps(16);
      check("wrapD", dRdData, LINE_C);
      check("wrapI", iRdData, LINE_C);

      // reset mid-write
      wrAddr = 32'h0000_2000; wrLine = LINE_A; wrReq = 1'b1;
      runSteps(L + 2);
      clearEdges();
      wrLine = LINE_B; wrReq = 1'b1;
      runSteps(2);
      rst = 1'b0;
      step();
      check("abortBusy", 128'(busy), 128'(0));
      check("abortPulses", 128'({wrDone, dRdValid, iRdValid}), 128'(0));
      check("abortDData", dRdData, 128'(0));
      check("abortIData", iRdData, 128'(0));
      rst = 1'b1; wrReq = 1'b0;
      runSteps(10);
      check("noWrDone", 128'(wrEdge), 128'(-1));
      dRdAddr = 32'h0000_2000; dRdReq = 1'b1;
      runSteps(L + 2);
      check("priorLine", dRdData, LINE_A);

      // instruction request dropped after sampling
      clearEdges(); e0 = edgeNo;
      iRdAddr = 32'h0000_1010; iRdReq = 1'b1;
      step();
      iRdReq = 1'b0;
      runSteps(L);
      check("dropIEdge", 128'(iEdge - e0), 128'(5));
      check("dropIData", iRdData, LINE_C);
      check("dropIdle", 128'(busy), 128'(0));

      // randomized traffic
      for (int n = 0; n < 2500; n++) begin
         if (!wrReq && $urandom_range(0, 5) == 0) begin
            wrReq = 1'b1; wrAddr = randAddr(); wrLine = randLine();
         end
         if (!dRdReq && $urandom_range(0, 4) == 0) begin
            dRdReq = 1'b1; dRdAddr = randAddr();
         end
         if (!iRdReq && $urandom_range(0, 4) == 0) begin
            iRdReq = 1'b1; iRdAddr = randAddr();
         end
         if ($urandom_range(0, 7) == 0) dRdAddr = randAddr();
         if ($urandom_range(0, 7) == 0) iRdAddr = randAddr();
         if ($urandom_range(0, 7) == 0) wrAddr = randAddr();
         if ($urandom_range(0, 7) == 0) wrLine = randLine();
         if ($urandom_range(0, 29) == 0) wrReq  = 1'b0;
         if ($urandom_range(0, 29) == 0) dRdReq = 1'b0;
         if ($urandom_range(0, 29) == 0) iRdReq = 1'b0;
         rst = ($urandom_range(0, 149) != 0);
         step();
      end
      rst = 1'b1;
      check("singlePulse", 128'(multiSeen), 128'(0));

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule

// File: doc/main_mem_responder.md
MAIN_MEM_RESPONDER -- requirements
Module: main_mem_responder

Interface
REQ-001 SHALL have parameter MEM_LATENCY, default 5, meaning cycles from request sample to response pulse (legal range 2..15).
REQ-002 SHALL have parameter LINE_IDX_BITS, default 10, meaning log2 of storage depth in 128-bit lines.
REQ-003 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-low reset.
REQ-005 SHALL have port dRdAddr, input, 32, data-side read byte address.
REQ-006 SHALL have port dRdReq, input, 1, data-side read request, level-held.
REQ-007 SHALL have port dRdData, output, 128, data-side read line.
REQ-008 SHALL have port dRdValid, output, 1, one-cycle data-side read completion.
REQ-009 SHALL have port iRdAddr, input, 32, instruction-side read byte address.
REQ-010 SHALL have port iRdReq, input, 1, instruction-side read request, level-held.
REQ-011 SHALL have port iRdData, output, 128, instruction-side read line.
REQ-012 SHALL have port iRdValid, output, 1, one-cycle instruction-side read completion.
REQ-013 SHALL have port wrAddr, input, 32, writeback byte address.
REQ-014 SHALL have port wrReq, input, 1, writeback request, level-held.
REQ-015 SHALL have port wrLine, input, 128, writeback line data.
REQ-016 SHALL have port wrDone, output, 1, one-cycle writeback completion.
REQ-017 SHALL have port busy, output, 1, high whenever state is not IDLE.

Function
REQ-018 SHALL store 2^LINE_IDX_BITS lines; line index = addr[LINE_IDX_BITS+3:4]; addr[3:0] and higher bits ignored (wrap modulo depth).
REQ-019 SHALL implement FSM IDLE -> BUSY -> RESP -> IDLE, serving one request at a time.
REQ-020 SHALL sample requests only in IDLE; priority wrReq > dRdReq > iRdReq; with no request, SHALL remain in IDLE.
REQ-021 SHALL latch grant, index and wrLine at the sampling edge; later input changes SHALL NOT affect the operation in flight.
REQ-022 SHALL hold BUSY with down-counter loaded to MEM_LATENCY-2, entering RESP when it reaches 0.
REQ-023 SHALL assert the granted completion (dRdValid, iRdValid or wrDone) for exactly the one cycle spent in RESP, i.e. high after the MEM_LATENCY-th rising edge, counting the sampling edge as edge 1.
REQ-024 SHALL commit a write to storage at the edge entering RESP; a read SHALL capture storage into dRdData/iRdData at that same edge.
REQ-025 SHALL hold dRdData and iRdData at their last captured value until the next read on that side completes.
REQ-026 SHALL return to IDLE after RESP; a request still high is re-sampled there, so back-to-back operations are spaced MEM_LATENCY+1 edges apart.
REQ-027 SHALL complete a granted operation, including its pulse and any write commit, even if its request drops mid-flight.
REQ-028 SHALL let a read granted after a write to the same line return the written data.
REQ-029 SHALL never assert more than one completion output in any cycle.

Reset
REQ-030 SHALL, with rst low at a rising edge, force IDLE, counter 0, dRdValid=iRdValid=wrDone=busy=0, dRdData=iRdData=0.
REQ-031 SHALL abort any in-flight operation on reset with no pulse and no write commit.
REQ-032 SHALL leave storage contents unchanged by reset.

Verification
REQ-033 Write 0x0123_4567_89AB_CDEF_0011_2233_4455_6677 to 0x1000, then read it on the data side -> wrDone one cycle at edge 5, dRdValid one cycle 6 edges later, dRdData equals written line.
REQ-034 dRdReq and iRdReq high in the same IDLE cycle -> dRdValid first, iRdValid exactly 6 edges later, never both in one cycle.
REQ-035 wrReq, dRdReq, iRdReq all high to the same line -> order wrDone, dRdValid, iRdValid; both reads return new data.
REQ-036 Read 0x1010 and 0x1010+(1024<<4) after writing only the first -> identical data (wrap-around).
REQ-037 rst low at edge 3 of a write -> no wrDone; later read returns prior line contents; all outputs 0 after reset.
REQ-038 Drop iRdReq after the sampling edge -> iRdValid still pulses at edge 5 with correct line; FSM then idle.
